// File: rtl/fight_pkg.sv
// fight_pkg: state codes and encodings shared by the gameplay controllers and the hit resolver.
package fight_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FWD       = 4'd1,
        ST_BWD       = 4'd2,
        ST_N_START   = 4'd3,
        ST_N_ACTIVE  = 4'd4,
        ST_N_RECOVER = 4'd5,
        ST_D_START   = 4'd6,
        ST_D_ACTIVE  = 4'd7,
        ST_D_RECOVER = 4'd8,
        ST_HITSTUN   = 4'd9,
        ST_BLOCKSTUN = 4'd10
    } pstate_t;

    typedef enum logic [1:0] {
        STUN_NONE  = 2'b00,
        STUN_HIT   = 2'b01,
        STUN_BLOCK = 2'b10
    } stun_t;

    typedef enum logic [1:0] {
        RS_FIGHT = 2'b00,
        RS_KO    = 2'b01,
        RS_OVER  = 2'b10
    } round_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } win_t;

    localparam int PLAYER_WIDTH = 64;

    function automatic logic is_active(input logic [3:0] s);
        return s == ST_N_ACTIVE || s == ST_D_ACTIVE;
    endfunction

endpackage

// File: rtl/hit_check.sv
// hit_check: combinational overlap test of one attacker's hitbox against the other player's hurtbox.
module hit_check
    import fight_pkg::*;
#(
    parameter int I_REACH = 32,
    parameter int D_REACH = 48
) (
    input  logic [9:0] atk_pos,
    input  logic [3:0] atk_state,
    input  logic [9:0] def_pos,
    input  logic [3:0] def_state,
    input  logic       side,
    output logic       connect,
    output logic       block,
    output logic [1:0] damage
);

    logic [10:0] left_pos;
    logic [10:0] right_pos;
    logic [10:0] reach;

    // side 0: attacker is P1 (left player); side 1: attacker is P2
    always_comb begin
        reach     = atk_state == ST_D_ACTIVE ? 11'(D_REACH) : 11'(I_REACH);
        left_pos  = {1'b0, side ? def_pos : atk_pos};
        right_pos = {1'b0, side ? atk_pos : def_pos};
        connect   = is_active(atk_state) && right_pos < left_pos + 11'(PLAYER_WIDTH) + reach;
        block     = def_state == ST_BWD || def_state == ST_BLOCKSTUN;
        damage    = block ? 2'd0 : atk_state == ST_D_ACTIVE ? 2'd2 : 2'd1;
    end

endmodule

// File: rtl/hit_resolver.sv
// hit_resolver: per-frame combat arbitration, health, round timer and round-state FSM.
module hit_resolver
    import fight_pkg::*;
#(
    parameter int I_REACH        = 32,
    parameter int D_REACH        = 48,
    parameter int MAX_HEALTH     = 5,
    parameter int FRAMES_PER_SEC = 60,
    parameter int ROUND_SECONDS  = 99,
    parameter int KO_FRAMES      = 90
) (
    input  logic       logic_clk,
    input  logic       reset_n,
    input  logic       restart,
    input  logic [9:0] p1_pos_x,
    input  logic [9:0] p2_pos_x,
    input  logic [3:0] p1_state,
    input  logic [3:0] p2_state,
    output logic [1:0] stunmode1,
    output logic [1:0] stunmode2,
    output logic [2:0] health1,
    output logic [2:0] health2,
    output logic [6:0] round_timer,
    output logic [1:0] round_state,
    output logic [1:0] winner
);

    localparam int PW = FRAMES_PER_SEC > 1 ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int KW = $clog2(KO_FRAMES + 1);

    round_t        state;
    round_t        state_nxt;
    logic [PW-1:0] presc;
    logic [KW-1:0] ko_cnt;
    logic          conn1;
    logic          conn2;
    logic          c1;
    logic          c2;
    logic          b1;
    logic          b2;
    logic [1:0]    d1;
    logic [1:0]    d2;
    logic          fight;
    logic          hit1;
    logic          hit2;
    logic [2:0]    h1_nxt;
    logic [2:0]    h2_nxt;
    logic          presc_wrap;
    logic [6:0]    timer_nxt;
    logic          ko_health;
    logic          time_up;
    logic [1:0]    win_nxt;

    hit_check #(.I_REACH(I_REACH), .D_REACH(D_REACH)) u_p1_atk (
        .atk_pos  (p1_pos_x),
        .atk_state(p1_state),
        .def_pos  (p2_pos_x),
        .def_state(p2_state),
        .side     (1'b0),
        .connect  (c1),
        .block    (b1),
        .damage   (d1)
    );

    hit_check #(.I_REACH(I_REACH), .D_REACH(D_REACH)) u_p2_atk (
        .atk_pos  (p2_pos_x),
        .atk_state(p2_state),
        .def_pos  (p1_pos_x),
        .def_state(p1_state),
        .side     (1'b1),
        .connect  (c2),
        .block    (b2),
        .damage   (d2)
    );

    assign round_state = state;

    // hit1: P1 lands on P2; hit2: P2 lands on P1. Health-0 outranks time-up.
    always_comb begin
        fight      = state == RS_FIGHT;
        hit1       = fight && c1 && !conn1;
        hit2       = fight && c2 && !conn2;
        h2_nxt     = hit1 ? (health2 > 3'(d1) ? health2 - 3'(d1) : 3'd0) : health2;
        h1_nxt     = hit2 ? (health1 > 3'(d2) ? health1 - 3'(d2) : 3'd0) : health1;
        presc_wrap = presc == PW'(FRAMES_PER_SEC - 1);
        timer_nxt  = fight && presc_wrap && round_timer != 7'd0 ? round_timer - 7'd1 : round_timer;
        ko_health  = h1_nxt == 3'd0 || h2_nxt == 3'd0;
        time_up    = timer_nxt == 7'd0;
        win_nxt    = ko_health ? (h1_nxt == 3'd0 && h2_nxt == 3'd0 ? WIN_DRAW :
                                  h1_nxt == 3'd0 ? WIN_P2 : WIN_P1) :
                     h1_nxt > h2_nxt ? WIN_P1 : h2_nxt > h1_nxt ? WIN_P2 : WIN_DRAW;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RS_FIGHT: state_nxt = ko_health || time_up ? RS_KO : RS_FIGHT;
            RS_KO:    state_nxt = ko_cnt == KW'(KO_FRAMES - 1) ? RS_OVER : RS_KO;
            RS_OVER:  state_nxt = restart ? RS_FIGHT : RS_OVER;
            default:  state_nxt = RS_FIGHT;
        endcase
    end

    always_ff @(posedge logic_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RS_FIGHT;
            stunmode1   <= STUN_NONE;
            stunmode2   <= STUN_NONE;
            health1     <= 3'(MAX_HEALTH);
            health2     <= 3'(MAX_HEALTH);
            round_timer <= 7'(ROUND_SECONDS);
            winner      <= WIN_NONE;
            presc       <= '0;
            ko_cnt      <= '0;
            conn1       <= 1'b0;
            conn2       <= 1'b0;
        end else begin
            state     <= state_nxt;
            stunmode1 <= hit2 ? (b2 ? STUN_BLOCK : STUN_HIT) : STUN_NONE;
            stunmode2 <= hit1 ? (b1 ? STUN_BLOCK : STUN_HIT) : STUN_NONE;
            conn1     <= is_active(p1_state) && (conn1 || hit1);
            conn2     <= is_active(p2_state) && (conn2 || hit2);
            if (fight) begin
                health1     <= h1_nxt;
                health2     <= h2_nxt;
                round_timer <= timer_nxt;
                presc       <= presc_wrap ? '0 : presc + PW'(1);
                ko_cnt      <= '0;
                if (state_nxt == RS_KO) winner <= win_nxt;
            end else if (state == RS_KO) begin
                ko_cnt <= ko_cnt + KW'(1);
            end else if (restart) begin
                health1     <= 3'(MAX_HEALTH);
                health2     <= 3'(MAX_HEALTH);
                round_timer <= 7'(ROUND_SECONDS);
                presc       <= '0;
                winner      <= WIN_NONE;
            end
        end
    end

endmodule

// File: tb/tb_hit_resolver.sv
// tb_hit_resolver: directed-vector bench for hit_resolver, with a short-round instance for time-up.
module tb_hit_resolver;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       restart;
    logic [9:0] p1_pos_x, p2_pos_x;
    logic [3:0] p1_state, p2_state;
    logic [1:0] stunmode1, stunmode2, round_state, winner;
    logic [2:0] health1, health2;
    logic [6:0] round_timer;
    logic [1:0] t_stun1, t_stun2, t_state, t_winner;
    logic [2:0] t_h1, t_h2;
    logic [6:0] t_timer;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hit_resolver u_dut (
        .logic_clk(clk), .reset_n(reset_n), .restart(restart),
        .p1_pos_x(p1_pos_x), .p2_pos_x(p2_pos_x),
        .p1_state(p1_state), .p2_state(p2_state),
        .stunmode1(stunmode1), .stunmode2(stunmode2),
        .health1(health1), .health2(health2),
        .round_timer(round_timer), .round_state(round_state), .winner(winner)
    );

    hit_resolver #(.FRAMES_PER_SEC(2), .ROUND_SECONDS(3)) u_tmr (
        .logic_clk(clk), .reset_n(reset_n), .restart(1'b0),
        .p1_pos_x(10'd0), .p2_pos_x(10'd900),
        .p1_state(4'd0), .p2_state(4'd0),
        .stunmode1(t_stun1), .stunmode2(t_stun2),
        .health1(t_h1), .health2(t_h2),
        .round_timer(t_timer), .round_state(t_state), .winner(t_winner)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int a_pos, input int a_st, input int b_pos, input int b_st);
        p1_pos_x = 10'(a_pos);
        p1_state = 4'(a_st);
        p2_pos_x = 10'(b_pos);
        p2_state = 4'(b_st);
    endtask

    initial begin
        reset_n = 1'b0;
        restart = 1'b0;
        drive(0, 0, 900, 0);
        step();
        step();
        check("rst_stun1", 32'(stunmode1), 0);
        check("rst_stun2", 32'(stunmode2), 0);
        check("rst_h1", 32'(health1), 5);
        check("rst_h2", 32'(health2), 5);
        check("rst_timer", 32'(round_timer), 99);
        check("rst_state", 32'(round_state), 0);
        check("rst_winner", 32'(winner), 0);
        reset_n = 1'b1;
        repeat (5) step();
        check("tu_state_e5", 32'(t_state), 0);
        check("tu_timer_e5", 32'(t_timer), 1);
        step();
        check("tu_state_e6", 32'(t_state), 1);
        check("tu_timer_e6", 32'(t_timer), 0);
        check("tu_winner", 32'(t_winner), 3);
        check("main_timer", 32'(round_timer), 99);
        // neutral hit, then held active frame
        drive(100, 4, 180, 0);
        step();
        check("nh_stun2", 32'(stunmode2), 1);
        check("nh_stun1", 32'(stunmode1), 0);
        check("nh_h2", 32'(health2), 4);
        step();
        check("nh2_stun2", 32'(stunmode2), 0);
        check("nh2_h2", 32'(health2), 4);
        drive(100, 5, 180, 0);
        step();
        // block, then out of reach
        drive(100, 7, 200, 2);
        step();
        check("blk_stun2", 32'(stunmode2), 2);
        check("blk_h2", 32'(health2), 4);
        drive(100, 0, 200, 2);
        step();
        drive(100, 7, 220, 2);
        step();
        check("far_stun2", 32'(stunmode2), 0);
        check("far_h2", 32'(health2), 4);
        drive(100, 0, 220, 0);
        step();
        // trade
        drive(100, 4, 170, 4);
        step();
        check("tr_stun1", 32'(stunmode1), 1);
        check("tr_stun2", 32'(stunmode2), 1);
        check("tr_h1", 32'(health1), 4);
        check("tr_h2", 32'(health2), 3);
        drive(100, 0, 170, 0);
        step();
        // directional hits down to KO
        drive(100, 7, 180, 0);
        step();
        check("d1_h2", 32'(health2), 1);
        drive(100, 0, 180, 0);
        step();
        drive(100, 7, 180, 0);
        step();
        check("ko_h2", 32'(health2), 0);
        check("ko_h1", 32'(health1), 4);
        check("ko_state", 32'(round_state), 1);
        check("ko_winner", 32'(winner), 1);
        drive(100, 0, 180, 0);
        repeat (89) step();
        check("ko_hold", 32'(round_state), 1);
        step();
        check("over_state", 32'(round_state), 2);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("rs_state", 32'(round_state), 0);
        check("rs_h1", 32'(health1), 5);
        check("rs_h2", 32'(health2), 5);
        check("rs_timer", 32'(round_timer), 99);
        check("rs_winner", 32'(winner), 0);
        drive(100, 4, 180, 0);
        step();
        check("rs_hit_h2", 32'(health2), 4);
        check("rs_hit_stun2", 32'(stunmode2), 1);
        // second KO, then async reset inside the KO phase
        drive(100, 0, 180, 0);
        step();
        drive(100, 7, 180, 0);
        step();
        drive(100, 0, 180, 0);
        step();
        drive(100, 7, 180, 0);
        step();
        check("ko2_state", 32'(round_state), 1);
        check("ko2_h2", 32'(health2), 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_stun2", 32'(stunmode2), 0);
        check("ar_h2", 32'(health2), 5);
        check("ar_state", 32'(round_state), 0);
        check("ar_winner", 32'(winner), 0);
        check("ar_timer", 32'(round_timer), 99);
        step();
        reset_n = 1'b1;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
